// File: rtl/serial_logic_unit.sv
// -----------------------------------------------------------------------------
// serial_logic_unit
//
// Bit-serial bitwise logic unit. An operand set (a, b, op) is accepted in IDLE,
// then one result bit per clock is produced LSB first from the operand LSBs,
// and the assembled result is presented in DONE until the consumer takes it.
// Accept-to-accept interval is WIDTH+2 cycles; there is no overlap.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand set a, b, op is presented
//   in_ready   out  block can accept an operand set (IDLE only)
//   a, b       in   operands, WIDTH bits
//   op         in   00=AND 01=OR 10=XOR 11=NAND
//   out_valid  out  result o is valid (DONE only)
//   out_ready  in   consumer accepts the result
//   o          out  assembled result, WIDTH bits
//   zero       out  o == 0, meaningful while out_valid is high
// -----------------------------------------------------------------------------
module serial_logic_unit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o,
   output logic             zero
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_AND  = 2'd0,
      OP_OR   = 2'd1,
      OP_XOR  = 2'd2,
      OP_NAND = 2'd3
   } op_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   op_t              op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] o_q, o_d;
   logic             bit_res;

   // One-bit datapath: only the current operand LSBs are ever evaluated.
   always_comb begin
      bit_res = 1'b0;
      case (op_q)
         OP_AND:  bit_res = a_q[0] & b_q[0];
         OP_OR:   bit_res = a_q[0] | b_q[0];
         OP_XOR:  bit_res = a_q[0] ^ b_q[0];
         OP_NAND: bit_res = ~(a_q[0] & b_q[0]);
         default: bit_res = 1'b0;
      endcase
   end

   // Next-state and datapath update.
   always_comb begin
      // NOTE: every variable gets a hold-value default first so no path
      // through the case leaves it unassigned, which would infer a latch.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      o_d     = o_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               op_d    = op_t'(op);
               cnt_d   = '0;
               o_d     = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            o_d[cnt_q] = bit_res;
            a_d        = a_q >> 1;
            b_d        = b_q >> 1;
            // Final bit is written on the same edge that leaves SHIFT.
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DONE: begin
            // o is held; only the handoff can leave this state.
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_AND;
         cnt_q   <= '0;
         o_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         o_q     <= o_d;
      end
   end

   // Handshake outputs decode registered state only.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign o         = o_q;
   assign zero      = (o_q == '0);

   // Structural invariants.
   cnt_in_range : assert property (@(posedge clk) disable iff (!rst_n)
      cnt_q <= CNT_LAST);
   state_legal : assert property (@(posedge clk) disable iff (!rst_n)
      state_q != 2'd3);

endmodule

// File: doc/serial_logic_unit.md
SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits; legal values 2..16.
REQ-002 Port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port in_valid, input, 1: operand set a, b, op is presented.
REQ-005 Port in_ready, output, 1: block can accept an operand set.
REQ-006 Port a, input, WIDTH: operand A.
REQ-007 Port b, input, WIDTH: operand B.
REQ-008 Port op, input, 2: operation select, where 00=AND, 01=OR, 10=XOR, 11=NAND.
REQ-009 Port out_valid, output, 1: result o is valid.
REQ-010 Port out_ready, input, 1: consumer accepts the result.
REQ-011 Port o, output, WIDTH: assembled result.
REQ-012 Port zero, output, 1: high when o equals 0; meaningful only while out_valid is high.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only; both are driven from registered state.
REQ-015 Accept: in IDLE, in_valid=1 at a rising edge latches a, b and op into shift registers, clears bit counter cnt to 0, clears o to 0, and moves to SHIFT.
REQ-016 in_valid SHALL be ignored in SHIFT and DONE; changes on a, b or op after accept SHALL NOT affect the result.
REQ-017 SHIFT: each rising edge computes one result bit from the operand LSBs using the latched op, writes it to o[cnt], right-shifts both operand registers, and increments cnt.
REQ-018 Order: bits SHALL be processed LSB first; exactly one bit per cycle; no gate evaluates more than one bit position per cycle.
REQ-019 When cnt = WIDTH-1 in SHIFT, the same edge SHALL write the final bit, move to DONE, and set cnt to 0; cnt never exceeds WIDTH-1.
REQ-020 Latency: out_valid SHALL rise exactly WIDTH clock cycles after the accepting edge.
REQ-021 DONE: o and zero SHALL hold stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-022 Handoff: in DONE, out_ready=1 at a rising edge moves to IDLE; in_ready is 1 in the following cycle; o retains its value until the next accept.
REQ-023 No throughput overlap: the minimum accept-to-accept interval SHALL be WIDTH+2 cycles when out_ready is tied to 1.
REQ-024 zero SHALL be computed from the registered o, with no additional cycle of latency.
REQ-025 out_ready in IDLE or SHIFT SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, cnt=0, o=0 and the operand and op registers to 0, giving in_ready=1, out_valid=0 and zero=1.
REQ-027 Reset asserted in SHIFT or DONE SHALL abort the operation, with no partial result ever flagged valid.
REQ-028 After rst_n deasserts, the first accept SHALL behave identically to one after power-up.

Verification
REQ-029 WIDTH=4, a=6, b=4, op=AND, out_ready=1 -> out_valid rises 4 cycles after accept; o=4, zero=0.
REQ-030 a=6, b=4, op=NAND -> o=0xB; a=0xF, b=0x5, op=XOR -> o=0xA; a=0x9, b=0x6, op=OR -> o=0xF; a=0x5, b=0xA, op=AND -> o=0, zero=1.
REQ-031 Backpressure: AND with a=6, b=4, out_ready held 0 for 5 cycles in DONE -> o=4 and out_valid=1 held throughout; IDLE is entered on the first edge with out_ready=1.
REQ-032 Operand corruption: accept a=6, b=4, AND, then drive a=0xF, b=0xF, op=OR with in_valid=1 during SHIFT -> result is still o=4, the second set is not accepted, and in_ready stays 0.
REQ-033 Reset mid-operation: assert rst_n=0 after 2 SHIFT cycles -> asynchronous return to in_ready=1, out_valid=0, o=0; the next accept of a=3, b=1, AND yields o=1.
REQ-034 Back-to-back: with out_ready=1 and in_valid=1 continuously -> accepts are spaced exactly 6 cycles apart at WIDTH=4.
